// File: rtl/fb_fifo_packer.sv
// fb_fifo_packer: drains a show-ahead FIFO and packs PACK words into one wide
// beat on a valid/ready stream. A flush closes a partial beat early.
module fb_fifo_packer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PACK  = 4,
    parameter int unsigned CNT_W = $clog2(PACK + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        fifo_out,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic                    flush,
    output logic [PACK*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    localparam logic [CNT_W-1:0] PackCnt = CNT_W'(PACK);
    localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PACK*WIDTH-1:0]   acc_q, acc_d;
    logic [PACK*WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    last_q, last_d;

    logic                    pop;
    logic [PACK*WIDTH-1:0]   acc_wr;
    logic [CNT_W-1:0]        cnt_inc;

    // Next-state: fill lanes in FILL, hold the beat in HOLD until the handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        pop     = 1'b0;
        acc_wr  = acc_q;
        cnt_inc = cnt_q;

        unique case (state_q)
            StFill: begin
                pop = !fifo_empty;
                if (pop) begin
                    for (int i = 0; i < int'(PACK); i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            acc_wr[i*WIDTH +: WIDTH] = fifo_out;
                        end
                    end
                end
                cnt_inc = cnt_q + CNT_W'(pop);
                // Close the beat when full, or on flush if anything is held.
                if (cnt_inc == PackCnt || (flush && cnt_inc != '0)) begin
                    state_d = StHold;
                    data_d  = acc_wr;
                    count_d = cnt_inc;
                    last_d  = flush;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_wr;
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                if (out_ready) begin
                    pop                 = !fifo_empty;
                    acc_wr              = '0;
                    acc_wr[WIDTH-1:0]   = fifo_out;
                    acc_d               = '0;
                    cnt_d               = '0;
                    if (pop && PackCnt == OneCnt) begin
                        // Single-word beats: the popped word is itself the next beat.
                        data_d  = acc_wr;
                        count_d = OneCnt;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StFill;
                        data_d  = '0;
                        count_d = '0;
                        last_d  = 1'b0;
                        if (pop) begin
                            // Zero-bubble restart: popped word lands in lane 0.
                            acc_d = acc_wr;
                            cnt_d = OneCnt;
                        end
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Outputs; reset suppresses the pop so no word is lost.
    always_comb begin
        fifo_pop  = pop & ~rst;
        out_data  = data_q;
        out_count = count_q;
        out_last  = last_q;
        out_valid = (state_q == StHold);
        busy      = (cnt_q != '0) || (state_q == StHold);
    end

endmodule

// File: tb/tb_fb_fifo_packer.sv
// Directed bench for fb_fifo_packer: PACK=4 instance for most cases, PACK=1 instance
// for the single-word-beat case. FIFOs are modelled with queues.
module tb_fb_fifo_packer;

    logic         clk = 1'b0;
    logic         rst, flush, ready4, ready1;
    logic [31:0]  fo4, fo1;
    logic         em4, em1;
    logic         pop4, pop1;
    logic [127:0] od4;
    logic [2:0]   oc4;
    logic         ol4, ov4, busy4;
    logic [31:0]  od1;
    logic [0:0]   oc1;
    logic         ol1, ov1, busy1;

    logic [31:0]  q4[$];
    logic [31:0]  q1[$];
    logic [127:0] rd4[$];
    logic [2:0]   rc4[$];
    logic         rl4[$];
    logic [31:0]  rd1[$];
    logic [0:0]   rc1[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] held;

    always #5 clk = ~clk;

    fb_fifo_packer #(.WIDTH(32), .PACK(4)) u_dut4 (
        .clk(clk), .rst(rst), .fifo_out(fo4), .fifo_empty(em4), .fifo_pop(pop4),
        .flush(flush), .out_data(od4), .out_count(oc4), .out_last(ol4),
        .out_valid(ov4), .out_ready(ready4), .busy(busy4)
    );

    fb_fifo_packer #(.WIDTH(32), .PACK(1)) u_dut1 (
        .clk(clk), .rst(rst), .fifo_out(fo1), .fifo_empty(em1), .fifo_pop(pop1),
        .flush(flush), .out_data(od1), .out_count(oc1), .out_last(ol1),
        .out_valid(ov1), .out_ready(ready1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fo4 = (q4.size() != 0) ? q4[0] : 32'h0;
        em4 = (q4.size() == 0);
        fo1 = (q1.size() != 0) ? q1[0] : 32'h0;
        em1 = (q1.size() == 0);
    endtask

    task automatic push4(input logic [31:0] w);
        q4.push_back(w);
        refresh();
    endtask

    // One clock: record handshakes and pops before the edge, update FIFOs after.
    task automatic step();
        logic p4, p1;
        #1;
        p4 = pop4;
        p1 = pop1;
        check_eq("pop4_when_empty", {127'd0, p4 & em4}, 128'd0);
        if (ov4 && ready4) begin
            rd4.push_back(od4);
            rc4.push_back(oc4);
            rl4.push_back(ol4);
        end
        if (ov1 && ready1) begin
            rd1.push_back(od1);
            rc1.push_back(oc1);
        end
        @(posedge clk);
        #1;
        if (p4) void'(q4.pop_front());
        if (p1) void'(q1.pop_front());
        refresh();
    endtask

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        ready4 = 1'b1;
        ready1 = 1'b1;
        refresh();
        step();
        step();
        // Reset state
        check_eq("rst_valid", {127'd0, ov4}, 128'd0);
        check_eq("rst_data", od4, 128'd0);
        check_eq("rst_count", {125'd0, oc4}, 128'd0);
        check_eq("rst_last", {127'd0, ol4}, 128'd0);
        check_eq("rst_busy", {127'd0, busy4}, 128'd0);
        rst = 1'b0;

        // 1: eight words, two full beats; beat visible after the 4th pop
        for (int i = 1; i <= 8; i++) push4(32'(i));
        for (int i = 0; i < 3; i++) step();
        check_eq("t1_not_yet_valid", {127'd0, ov4}, 128'd0);
        step();
        check_eq("t1_valid_after_4", {127'd0, ov4}, 128'd1);
        check_eq("t1_first_data", od4, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 8; i++) step();
        check_eq("t1_beats", 128'(rd4.size()), 128'd2);
        if (rd4.size() == 2) begin
            check_eq("t1_beat0", rd4[0], 128'h00000004_00000003_00000002_00000001);
            check_eq("t1_beat1", rd4[1], 128'h00000008_00000007_00000006_00000005);
            check_eq("t1_count0", {125'd0, rc4[0]}, 128'd4);
            check_eq("t1_last1", {127'd0, rl4[1]}, 128'd0);
        end
        check_eq("t1_busy_end", {127'd0, busy4}, 128'd0);
        rd4.delete(); rc4.delete(); rl4.delete();

        // 2: three words then flush -> partial beat
        push4(32'hA); push4(32'hB); push4(32'hC);
        for (int i = 0; i < 3; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t2_valid", {127'd0, ov4}, 128'd1);
        check_eq("t2_data", od4, 128'h00000000_0000000C_0000000B_0000000A);
        check_eq("t2_count", {125'd0, oc4}, 128'd3);
        check_eq("t2_last", {127'd0, ol4}, 128'd1);
        step();
        check_eq("t2_beats", 128'(rd4.size()), 128'd1);
        rd4.delete(); rc4.delete(); rl4.delete();

        // 3: flush when empty is ignored; flush in HOLD leaves the beat alone
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t3_idle_valid", {127'd0, ov4}, 128'd0);
        check_eq("t3_idle_busy", {127'd0, busy4}, 128'd0);
        ready4 = 1'b0;
        for (int i = 0; i < 4; i++) push4(32'h11 + 32'(i));
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t3_hold_data", od4, 128'h00000014_00000013_00000012_00000011);
        check_eq("t3_hold_last", {127'd0, ol4}, 128'd0);
        check_eq("t3_hold_count", {125'd0, oc4}, 128'd4);

        // 4: backpressure for 5 cycles, then zero-bubble restart
        for (int i = 0; i < 4; i++) push4(32'h21 + 32'(i));
        held = od4;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t4_no_pop", {127'd0, pop4}, 128'd0);
            step();
            check_eq("t4_stable", od4, held);
        end
        ready4 = 1'b1;
        #1;
        check_eq("t4_pop_on_hs", {127'd0, pop4}, 128'd1);
        step();
        check_eq("t4_valid_drop", {127'd0, ov4}, 128'd0);
        check_eq("t4_busy_cnt1", {127'd0, busy4}, 128'd1);
        check_eq("t4_beats", 128'(rd4.size()), 128'd1);
        for (int i = 0; i < 3; i++) step();
        ready4 = 1'b0;
        check_eq("t4_next_data", od4, 128'h00000024_00000023_00000022_00000021);

        // 5: reset with a beat held, then with two words accumulated
        push4(32'h31); push4(32'h32);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_nopop_a", {127'd0, pop4}, 128'd0);
        step();
        check_eq("t5_valid_a", {127'd0, ov4}, 128'd0);
        check_eq("t5_busy_a", {127'd0, busy4}, 128'd0);
        check_eq("t5_fifo_kept", 128'(q4.size()), 128'd2);
        rst    = 1'b0;
        ready4 = 1'b1;
        step();
        step();
        check_eq("t5_busy_acc", {127'd0, busy4}, 128'd1);
        push4(32'h33);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_nopop_b", {127'd0, pop4}, 128'd0);
        step();
        check_eq("t5_busy_b", {127'd0, busy4}, 128'd0);
        rst = 1'b0;
        push4(32'h34); push4(32'h35); push4(32'h36);
        for (int i = 0; i < 4; i++) step();
        check_eq("t5_repack", od4, 128'h00000036_00000035_00000034_00000033);
        step();

        // 6: PACK=1, one beat per cycle
        rd1.delete(); rc1.delete();
        for (int i = 0; i < 6; i++) q1.push_back(32'h51 + 32'(i));
        refresh();
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("t6_pop_high", {127'd0, pop1}, 128'd1);
            step();
        end
        step();
        check_eq("t6_beats", 128'(rd1.size()), 128'd6);
        for (int i = 0; i < rd1.size(); i++) begin
            check_eq("t6_data", {96'd0, rd1[i]}, {96'd0, 32'h51 + 32'(i)});
            check_eq("t6_count", {127'd0, rc1[i]}, 128'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
